timer_periph: RTL and testbench
===============================

# timer_periph

Memory-mapped programmable interval timer on the pipeline CPU's data-memory bus. It is the writable counterpart to the free-running read-only system clock counter.
- Software loads a reload value and a start value, then enables counting.
- On each count overflow the block reloads the counter, increments an overflow tally and, when enabled, raises a level interrupt to the CPU until software clears it.

## Interface
Parameters:
- BASE_ADDR, 32'h40000000, word-aligned base of the 4-register window

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately while low
- Address  in  32  byte address from the CPU memory stage
- MemRead  in  1  read strobe
- MemWrite  in  1  write strobe
- WriteData  in  32  store data
- ReadData  out  32  load data; combinational
- irq  out  1  interrupt request to the CPU; level-sensitive

## Operation
Register map (offset from BASE_ADDR; only Address bits [3:2] are decoded once the window matches; bits [1:0] are ignored):
- 0x0 TH: reload value, R/W.
- 0x4 TL: counter, R/W.
- 0x8 TCON: control/status.
  - Bit 0 EN: count enable, R/W.
  - Bit 1 IE: interrupt enable, R/W.
  - Bit 2 ST: interrupt status, read / write-0-to-clear.
  - Bits 31:3 read 0.
- 0xC OVF: overflow tally, 32 bits, read-only; any write clears it to 0.
- Window hit: Address[31:4] == BASE_ADDR[31:4].

Counting, evaluated each edge when EN=1:
- TL != 32'hFFFFFFFF: TL <= TL + 1.
- TL == 32'hFFFFFFFF: overflow.
  - TL <= TH.
  - OVF <= OVF + 1, wrapping modulo 2^32.
  - If IE=1, ST <= 1.
- EN=0: TL, OVF and ST hold.

Writes: MemWrite=1 with a window hit updates the addressed register at the edge.
- TH write: TH <= WriteData.
- TL write: TL <= WriteData. It overrides both the increment and the overflow reload in that cycle, and no overflow is counted in that cycle.
- TCON write: EN <= WriteData[0], IE <= WriteData[1], ST <= ST & WriteData[2] (software can never set ST).
  - The new EN/IE values take effect from the next cycle. The counting decision in the write cycle uses the old EN/IE.
  - An overflow in the same cycle as a TCON write that clears ST leaves ST=1 (set wins).
- OVF write: OVF <= 0. An overflow in the same cycle leaves OVF = 1.
- Writes outside the window, or with MemWrite=0, change nothing.

Reads:
- ReadData = addressed register when MemRead=1 and the window hits.
- ReadData = 0 otherwise, including MemRead=0.
- Reads have no side effects.

Interrupt: irq = IE & ST.
- Clearing IE masks irq but preserves ST.
- Re-enabling IE with ST still set reasserts irq.

## Timing
- Reset values: TH=0, TL=0, TCON=0, OVF=0, irq=0. ReadData=0 unless a read of a register is presented.
- Reset mid-count returns every register to 0 asynchronously. The first increment occurs only after software sets EN again.
- Write-to-effect latency is one edge. The register holds the new value from the cycle after the write.
- Read latency is zero (combinational).
- Overflow to irq: ST and irq rise in the cycle after the edge where TL was 32'hFFFFFFFF.
- Overflow period with EN held: (2^32 - TH) cycles between reloads. With TH = 32'hFFFFFFFF the block overflows every cycle, so TL stays at 32'hFFFFFFFF and OVF increments every cycle.
- MemRead and MemWrite asserted together to the same register: ReadData shows the pre-write value and the write commits at the edge.

## Test plan
- Reset check:
  - Stimulus: reset low mid-count after TL=5, EN=1.
  - Response: TL, TH, TCON, OVF and irq are all 0 immediately. TL stays 0 for 10 cycles after reset is released with no writes.
- Overflow and reload:
  - Stimulus: TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, then TCON=3.
  - Response: TL reads FFFFFFFF one cycle after EN takes effect, then FFFFFFFC. ST=1, irq=1 and OVF=1 that same cycle. The next overflow follows exactly 4 cycles later, with OVF=2.
- Clear race:
  - Stimulus: TCON write of 32'h3 (clears ST) on the exact edge TL wraps.
  - Response: ST stays 1 and irq stays 1. A later TCON=3 write with no overflow clears irq the next cycle.
- TL write priority:
  - Stimulus: write TL=32'h10 on the wrap edge, with TH=0, EN=1, IE=1.
  - Response: TL=32'h10 and TL=32'h11 on the following cycles; OVF unchanged and irq=0.
- Masking:
  - Stimulus: with ST=1, write TCON=32'h5 (IE=0, ST kept).
  - Response: irq=0 while TCON reads 5. Then write TCON=7: irq=1 the next cycle.
- Decode:
  - Stimulus: read BASE+0x10, or read with MemRead=0; write BASE+0xC with 32'hFFFF while OVF=3.
  - Response: both reads return 0. OVF reads 0 after the write, and TH/TL/TCON are unchanged.

Source files
------------

// File: rtl/timer_periph.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control/status, OVF overflow tally.
// Writes commit at the clock edge, reads are combinational, and irq is IE & ST.
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [31:0] r_ovf;
  logic        r_en;
  logic        r_ie;
  logic        r_st;

  logic        w_hit;
  logic        w_wr;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_wr_ovf;
  logic        w_ovf;
  logic        w_unused_addr;

  assign w_hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign w_wr          = MemWrite & w_hit;
  assign w_wr_th       = w_wr & (Address[3:2] == 2'd0);
  assign w_wr_tl       = w_wr & (Address[3:2] == 2'd1);
  assign w_wr_tcon     = w_wr & (Address[3:2] == 2'd2);
  assign w_wr_ovf      = w_wr & (Address[3:2] == 2'd3);
  assign w_unused_addr = ^Address[1:0];

  // A software TL write suppresses the wrap entirely: no reload, no tally, no status.
  assign w_ovf = r_en & (r_tl == 32'hFFFFFFFF) & ~w_wr_tl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th  <= 32'd0;
      r_tl  <= 32'd0;
      r_ovf <= 32'd0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_st  <= 1'b0;
    end else begin
      if (w_wr_th) r_th <= WriteData;

      if (w_wr_tl)    r_tl <= WriteData;
      else if (w_ovf) r_tl <= r_th;
      else if (r_en)  r_tl <= r_tl + 32'd1;

      if (w_wr_tcon) begin
        r_en <= WriteData[0];
        r_ie <= WriteData[1];
      end

      // Hardware set beats a software clear landing on the same edge.
      if (w_ovf & r_ie)   r_st <= 1'b1;
      else if (w_wr_tcon) r_st <= r_st & WriteData[2];

      if (w_wr_ovf)   r_ovf <= {31'd0, w_ovf};
      else if (w_ovf) r_ovf <= r_ovf + 32'd1;
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (MemRead & w_hit) begin
      case (Address[3:2])
        2'd0:    ReadData = r_th;
        2'd1:    ReadData = r_tl;
        2'd2:    ReadData = {29'd0, r_st, r_ie, r_en};
        default: ReadData = r_ovf;
      endcase
    end
  end

  assign irq = r_ie & r_st;

endmodule

// File: tb/tb_timer_periph.sv
// Directed vector bench for timer_periph: one table of edge/check steps plus hand-written corner sequences.
module tb_timer_periph;

  localparam logic [31:0] B = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        step;   // 1: advance one clock edge (with optional write) before checking
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  timer_periph #(.BASE_ADDR(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic step, input logic we, input logic [31:0] waddr,
                     input logic [31:0] wdata, input logic rd, input logic [31:0] raddr,
                     input logic [31:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.step = step; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.rd = rd; v.raddr = raddr; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    vq.push_back(v);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; Address = 32'd0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1; #1;
    check(name, ReadData, exp);
    MemRead = 1'b0; Address = 32'd0;
  endtask

  initial begin
    reset = 1'b0; Address = 32'd0; MemRead = 1'b0; MemWrite = 1'b0; WriteData = 32'd0;

    // reset state
    add(0,0,0,0,1,B+32'h0,32'h0,0);
    add(0,0,0,0,1,B+32'h4,32'h0,0);
    add(0,0,0,0,1,B+32'h8,32'h0,0);
    add(0,0,0,0,1,B+32'hC,32'h0,0);
    // overflow and reload, period 4 with TH=FFFFFFFC
    add(1,1,B+32'h0,32'hFFFFFFFC,1,B+32'h0,32'hFFFFFFFC,0);
    add(1,1,B+32'h4,32'hFFFFFFFE,1,B+32'h4,32'hFFFFFFFE,0);
    add(1,1,B+32'h8,32'h3,1,B+32'h4,32'hFFFFFFFE,0);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFF,0);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFC,1);
    add(0,0,0,0,1,B+32'hC,32'h1,1);
    add(0,0,0,0,1,B+32'h8,32'h7,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFD,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFE,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFF,1);
    add(0,0,0,0,1,B+32'hC,32'h1,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFC,1);
    add(0,0,0,0,1,B+32'hC,32'h2,1);
    // clear racing the wrap edge: set wins
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFD,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFE,1);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFF,1);
    add(1,1,B+32'h8,32'h3,1,B+32'h8,32'h7,1);
    add(0,0,0,0,1,B+32'hC,32'h3,1);
    add(0,0,0,0,1,B+32'h4,32'hFFFFFFFC,1);
    add(1,1,B+32'h8,32'h3,1,B+32'h8,32'h3,0);
    // masking and re-enable
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFE,0);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFF,0);
    add(1,0,0,0,1,B+32'h4,32'hFFFFFFFC,1);
    add(0,0,0,0,1,B+32'h8,32'h7,1);
    add(0,0,0,0,1,B+32'hC,32'h4,1);
    add(1,1,B+32'h8,32'h5,1,B+32'h8,32'h5,0);
    add(1,1,B+32'h8,32'h7,1,B+32'h8,32'h7,1);
    // TL write on the wrap edge beats reload
    add(1,1,B+32'h8,32'h2,1,B+32'h8,32'h2,0);
    add(1,1,B+32'h0,32'h0,1,B+32'h4,32'hFFFFFFFF,0);
    add(1,1,B+32'h8,32'h3,1,B+32'h0,32'h0,0);
    add(1,1,B+32'h4,32'h10,1,B+32'h4,32'h10,0);
    add(0,0,0,0,1,B+32'hC,32'h4,0);
    add(0,0,0,0,1,B+32'h8,32'h3,0);
    add(1,0,0,0,1,B+32'h4,32'h11,0);
    // decode
    add(0,0,0,0,1,B+32'h10,32'h0,0);
    add(0,0,0,0,0,B+32'h4,32'h0,0);
    add(1,1,B+32'hC,32'hFFFF,1,B+32'hC,32'h0,0);
    add(0,0,0,0,1,B+32'h0,32'h0,0);
    add(0,0,0,0,1,B+32'h8,32'h3,0);
    add(0,0,0,0,1,B+32'h4,32'h12,0);
    add(1,1,B+32'h14,32'h55,1,B+32'h6,32'h13,0);
    // TH=FFFFFFFF overflows every cycle; OVF write vs overflow
    add(1,1,B+32'h8,32'h0,1,B+32'h4,32'h14,0);
    add(1,1,B+32'h0,32'hFFFFFFFF,1,B+32'h0,32'hFFFFFFFF,0);
    add(1,1,B+32'h4,32'hFFFFFFFF,1,B+32'h4,32'hFFFFFFFF,0);
    add(1,1,B+32'h8,32'h1,1,B+32'h4,32'hFFFFFFFF,0);
    add(0,0,0,0,1,B+32'hC,32'h0,0);
    add(1,0,0,0,1,B+32'hC,32'h1,0);
    add(1,0,0,0,1,B+32'hC,32'h2,0);
    add(0,0,0,0,1,B+32'h4,32'hFFFFFFFF,0);
    add(0,0,0,0,1,B+32'h8,32'h1,0);
    add(1,1,B+32'hC,32'h0,1,B+32'hC,32'h1,0);

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      if (vq[i].step) begin
        Address = vq[i].waddr; WriteData = vq[i].wdata; MemWrite = vq[i].we;
        @(posedge clk); #1;
        MemWrite = 1'b0;
      end
      Address = vq[i].raddr; MemRead = vq[i].rd; #1;
      check($sformatf("vec%0d rd", i), ReadData, vq[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vq[i].exp_irq});
      MemRead = 1'b0; Address = 32'd0;
    end

    // simultaneous read and write: read shows pre-write value
    Address = B; WriteData = 32'h1234; MemWrite = 1'b1; MemRead = 1'b1; #1;
    check("rw_pre", ReadData, 32'hFFFFFFFF);
    @(posedge clk); #1;
    MemWrite = 1'b0; #1;
    check("rw_post", ReadData, 32'h1234);
    MemRead = 1'b0; Address = 32'd0;

    // asynchronous reset in the middle of counting
    do_write(B+32'h4, 32'h5);
    do_write(B+32'h8, 32'h3);
    read_chk("pre_rst_tl", B+32'h4, 32'h6);
    #1 reset = 1'b0; #1;
    read_chk("rst_th", B+32'h0, 32'h0);
    read_chk("rst_tl", B+32'h4, 32'h0);
    read_chk("rst_tcon", B+32'h8, 32'h0);
    read_chk("rst_ovf", B+32'hC, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      read_chk($sformatf("post_rst_tl%0d", k), B+32'h4, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
